// File: rtl/e_mul_div_unit.sv
// e_mul_div_unit: execute-stage multiply/divide unit owning the architectural HI/LO registers.
// One operation is accepted per start pulse. Its result is computed from the operands at the
// start edge, held pending for a fixed latency, then committed to HI/LO. mthi/mtlo write
// HI/LO directly when the unit is idle.
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  - busy cycles for div/divu (>= 1)
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  synchronous, active-low reset
//   a       in  32  rs operand
//   b       in  32  rt operand
//   mdu_sel in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   start   in   1  one-cycle request qualifying mdu_sel 1-4
//   busy    out  1  high while an operation is in flight
//   hi      out 32  HI register
//   lo      out 32  LO register
module e_mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdu_sel,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] SelMult  = 3'd1;
  localparam logic [2:0] SelMultu = 3'd2;
  localparam logic [2:0] SelDiv   = 3'd3;
  localparam logic [2:0] SelDivu  = 3'd4;
  localparam logic [2:0] SelMthi  = 3'd5;
  localparam logic [2:0] SelMtlo  = 3'd6;

  // Single-bit encoding so busy is a direct flop output.
  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic [31:0]       r_hi, w_hi_next;
  logic [31:0]       r_lo, w_lo_next;
  logic [31:0]       r_res_hi, w_res_hi_next;
  logic [31:0]       r_res_lo, w_res_lo_next;
  logic              r_res_valid, w_res_valid_next;

  // Arithmetic on the live operands, captured at the start edge.
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_a_neg, w_b_neg, w_b_zero;
  logic [31:0]        w_a_mag, w_b_mag;
  logic [31:0]        w_den_u, w_den_s;
  logic [31:0]        w_quot_u, w_rem_u;
  logic [31:0]        w_quot_m, w_rem_m;
  logic [31:0]        w_quot_s, w_rem_s;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  assign w_a_neg  = a[31];
  assign w_b_neg  = b[31];
  assign w_b_zero = (b == 32'd0);
  // Magnitudes as unsigned; -0x80000000 stays 0x80000000, which is the correct magnitude.
  assign w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 32'd1) : b;
  // Zero divisors are replaced by 1 to keep the dividers defined; such results are discarded.
  assign w_den_u  = w_b_zero ? 32'd1 : b;
  assign w_den_s  = w_b_zero ? 32'd1 : w_b_mag;

  assign w_quot_u = a / w_den_u;
  assign w_rem_u  = a % w_den_u;
  assign w_quot_m = w_a_mag / w_den_s;
  assign w_rem_m  = w_a_mag % w_den_s;
  // Truncation toward zero: quotient sign from operand signs, remainder sign from dividend.
  // 0x80000000 / -1 yields magnitude 0x80000000, negated back to 0x80000000.
  assign w_quot_s = (w_a_neg ^ w_b_neg) ? (~w_quot_m + 32'd1) : w_quot_m;
  assign w_rem_s  = w_a_neg ? (~w_rem_m + 32'd1) : w_rem_m;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_hi_next        = r_hi;
    w_lo_next        = r_lo;
    w_res_hi_next    = r_res_hi;
    w_res_lo_next    = r_res_lo;
    w_res_valid_next = r_res_valid;

    case (r_state)
      StIdle: begin
        if (start) begin
          case (mdu_sel)
            SelMult: begin
              w_res_hi_next    = w_prod_s[63:32];
              w_res_lo_next    = w_prod_s[31:0];
              w_res_valid_next = 1'b1;
              w_cnt_next       = CntW'(MULT_CYCLES);
              w_state_next     = StRun;
            end
            SelMultu: begin
              w_res_hi_next    = w_prod_u[63:32];
              w_res_lo_next    = w_prod_u[31:0];
              w_res_valid_next = 1'b1;
              w_cnt_next       = CntW'(MULT_CYCLES);
              w_state_next     = StRun;
            end
            SelDiv: begin
              w_res_hi_next    = w_rem_s;
              w_res_lo_next    = w_quot_s;
              w_res_valid_next = ~w_b_zero;
              w_cnt_next       = CntW'(DIV_CYCLES);
              w_state_next     = StRun;
            end
            SelDivu: begin
              w_res_hi_next    = w_rem_u;
              w_res_lo_next    = w_quot_u;
              w_res_valid_next = ~w_b_zero;
              w_cnt_next       = CntW'(DIV_CYCLES);
              w_state_next     = StRun;
            end
            default: ;
          endcase
        end
        // Moves to HI/LO do not need start and never open a busy period.
        if (mdu_sel == SelMthi) w_hi_next = a;
        if (mdu_sel == SelMtlo) w_lo_next = a;
      end

      StRun: begin
        w_cnt_next = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          if (r_res_valid) begin
            w_hi_next = r_res_hi;
            w_lo_next = r_res_lo;
          end
          w_res_valid_next = 1'b0;
          w_state_next     = StIdle;
        end
      end

      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_hi        <= w_hi_next;
      r_lo        <= w_lo_next;
      r_res_hi    <= w_res_hi_next;
      r_res_lo    <= w_res_lo_next;
      r_res_valid <= w_res_valid_next;
    end
  end

  assign busy = (r_state == StRun);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_e_mul_div_unit.sv
// Testbench for e_mul_div_unit: directed vector table, hand sequences for busy-time input
// filtering and mid-operation reset, then random operations against a 64-bit arithmetic model.
module tb_e_mul_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  mdu_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference HI/LO state for the random phase.
  logic [31:0] m_hi, m_lo;

  e_mul_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .mdu_sel(mdu_sel),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, count busy cycles until idle, then check HI/LO.
  task automatic apply(input string name, input logic st, input logic [2:0] sel,
                       input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    int n;
    start   = st;
    mdu_sel = sel;
    a       = ia;
    b       = ib;
    tick();
    start   = 1'b0;
    mdu_sel = 3'd0;
    a       = 32'd0;
    b       = 32'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk({name, " busy cycles"}, 32'(n), 32'(ecyc));
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
  endtask

  // Architectural effect of one request, from plain 64-bit arithmetic.
  task automatic model_op(input logic st, input logic [2:0] sel,
                          input logic [31:0] ia, input logic [31:0] ib, output int cyc);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa  = longint'($signed(ia));
    sb  = longint'($signed(ib));
    ua  = {32'd0, ia};
    ub  = {32'd0, ib};
    cyc = 0;
    if (st && sel >= 3'd1 && sel <= 3'd4) begin
      cyc = (sel <= 3'd2) ? MC : DC;
      case (sel)
        3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
        3'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
        3'd3: if (ib != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        default: if (ib != 0) begin qu = ua / ub; ru = ua % ub; m_lo = qu[31:0]; m_hi = ru[31:0]; end
      endcase
    end else if (sel == 3'd5) begin
      m_hi = ia;
    end else if (sel == 3'd6) begin
      m_lo = ia;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    logic        r_st;
    logic [2:0]  r_sel;
    logic [31:0] r_a, r_b, prev_hi;

    // Load HI/LO, then reset with an mthi presented: reset must win.
    reset = 1'b1; start = 1'b0; mdu_sel = 3'd5; a = 32'hAAAA_AAAA; b = 32'd0;
    tick();
    mdu_sel = 3'd6; a = 32'h5555_5555;
    tick();
    reset = 1'b0; mdu_sel = 3'd5; a = 32'hBBBB_BBBB;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1; mdu_sel = 3'd0; a = 32'd0;

    // Each entry starts in the first idle cycle after the previous one (back-to-back).
    tbl.push_back(vec_t'{"mult -3*5",   1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5,
                         32'hFFFF_FFFF, 32'hFFFF_FFF1, MC});
    tbl.push_back(vec_t'{"multu",       1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2,
                         32'h0000_0001, 32'hFFFF_FFFE, MC});
    tbl.push_back(vec_t'{"divu 7/2",    1'b1, 3'd4, 32'd7, 32'd2,
                         32'd1, 32'd3, DC});
    tbl.push_back(vec_t'{"div -7/2",    1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2,
                         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC});
    tbl.push_back(vec_t'{"div ovf",     1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'd0, 32'h8000_0000, DC});
    tbl.push_back(vec_t'{"mthi",        1'b0, 3'd5, 32'h0000_1234, 32'd0,
                         32'h0000_1234, 32'h8000_0000, 0});
    tbl.push_back(vec_t'{"mtlo+start",  1'b1, 3'd6, 32'h0000_5678, 32'd0,
                         32'h0000_1234, 32'h0000_5678, 0});
    tbl.push_back(vec_t'{"sel7 start",  1'b1, 3'd7, 32'hDEAD_BEEF, 32'd3,
                         32'h0000_1234, 32'h0000_5678, 0});
    tbl.push_back(vec_t'{"sel0 start",  1'b1, 3'd0, 32'hDEAD_BEEF, 32'd3,
                         32'h0000_1234, 32'h0000_5678, 0});
    tbl.push_back(vec_t'{"divu by 0",   1'b1, 3'd4, 32'd9, 32'd0,
                         32'h0000_1234, 32'h0000_5678, DC});
    tbl.push_back(vec_t'{"div by 0",    1'b1, 3'd3, 32'hFFFF_FFF0, 32'd0,
                         32'h0000_1234, 32'h0000_5678, DC});
    tbl.push_back(vec_t'{"mult no st",  1'b0, 3'd1, 32'd3, 32'd3,
                         32'h0000_1234, 32'h0000_5678, 0});

    foreach (tbl[i]) begin
      apply(tbl[i].name, tbl[i].st, tbl[i].sel, tbl[i].a, tbl[i].b,
            tbl[i].ehi, tbl[i].elo, tbl[i].cyc);
    end

    // start+div and mthi presented while a mult is in flight are both dropped.
    prev_hi = 32'h0000_1234;
    start = 1'b1; mdu_sel = 3'd1; a = 32'd6; b = 32'd7;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        start = 1'b1; mdu_sel = 3'd3; a = 32'd100; b = 32'd7;
      end else if (n == 2) begin
        start = 1'b0; mdu_sel = 3'd5; a = 32'h0000_DEAD; b = 32'd0;
      end else begin
        if (n == 3) chk("busy ignore hi held", hi, prev_hi);
        start = 1'b0; mdu_sel = 3'd0; a = 32'd0; b = 32'd0;
      end
      tick();
    end
    start = 1'b0; mdu_sel = 3'd0; a = 32'd0; b = 32'd0;
    chk("busy ignore cycles", 32'(n), 32'(MC));
    chk("busy ignore hi", hi, 32'd0);
    chk("busy ignore lo", lo, 32'd42);
    tick();
    chk("busy ignore no div", {31'd0, busy}, 32'd0);

    // Reset in the third busy cycle of div 100/7 discards the pending result.
    start = 1'b1; mdu_sel = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; mdu_sel = 3'd0; a = 32'd0; b = 32'd0;
    tick();
    tick();
    chk("mid reset busy before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset hi", hi, 32'd0);
    chk("mid reset lo", lo, 32'd0);
    for (int i = 0; i < DC + 4; i++) tick();
    chk("mid reset no commit busy", {31'd0, busy}, 32'd0);
    chk("mid reset no commit hi", hi, 32'd0);
    chk("mid reset no commit lo", lo, 32'd0);

    // Random operations against the arithmetic model.
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int k = 0; k < 60; k++) begin
      r_st  = ($urandom_range(0, 3) != 0);
      r_sel = 3'($urandom_range(0, 7));
      r_a   = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = $urandom_range(1, 9);
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
      model_op(r_st, r_sel, r_a, r_b, cyc);
      apply($sformatf("rand%0d sel%0d st%0d", k, r_sel, r_st), r_st, r_sel, r_a, r_b,
            m_hi, m_lo, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
